// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_MULDIV
  } cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFS = 2'b11;

  // alt selects SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_op_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational classifier of a latched RV32I instruction.
// CTRL_MULDIV_EN adds RV32M decode under funct7 0000001.
module control_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output cls_e       cls_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] src_b_o,
  output logic       legal_o
);

  always_comb begin
    cls_o    = CLS_ALU;
    alu_op_o = ALU_ADD;
    src_b_o  = SRCB_RS2;
    legal_o  = 1'b0;
    case (opcode_i)
      OP_R: begin
        if (funct7_i == F7_BASE) begin
          alu_op_o = alu_op_f3(funct3_i, 1'b0);
          legal_o  = 1'b1;
        end else if (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
          alu_op_o = alu_op_f3(funct3_i, 1'b1);
          legal_o  = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (funct7_i == F7_MULDIV) begin
          cls_o    = CLS_MULDIV;
          alu_op_o = funct3_i[2] ? {2'b11, funct3_i[1:0]} : ALU_MUL + {2'b00, funct3_i[1:0]};
          legal_o  = 1'b1;
        end
`endif
      end
      OP_I: begin
        // funct7 is immediate data except for the shift-immediate forms
        src_b_o  = SRCB_IMM;
        alu_op_o = alu_op_f3(funct3_i, funct3_i == 3'b101 && funct7_i == F7_ALT);
        case (funct3_i)
          3'b001:  legal_o = (funct7_i == F7_BASE);
          3'b101:  legal_o = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
          default: legal_o = 1'b1;
        endcase
      end
      OP_LOAD: begin
        cls_o   = CLS_LOAD;
        src_b_o = SRCB_OFS;
        legal_o = (funct3_i == 3'b010);
      end
      OP_STORE: begin
        cls_o   = CLS_STORE;
        src_b_o = SRCB_OFS;
        legal_o = (funct3_i == 3'b010);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I control FSM: IDLE/DECODE/EXEC/MEM/WB/TRAP with memory timeout.
// CTRL_MULDIV_EN adds the MulDivDone input and RV32M decode.
module control_unit_mc
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 InstrValid,
  input  logic [31:0]          Instr,
  output logic                 InstrReady,
  input  logic                 DmemAck,
`ifdef CTRL_MULDIV_EN
  input  logic                 MulDivDone,
`endif
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 ALUSourceA,
  output logic [1:0]           ALUSourceB,
  output logic                 Dmem1ALUOUT,
  output logic                 DmemREB,
  output logic                 DmemWEB,
  output logic                 LoadStoremuxsel,
  output logic                 regWrite,
  output logic                 Busy,
  output logic                 IllegalInstr,
  output logic                 MemTimeout
);

  state_e     state_q, state_d;
  logic [6:0] op_q, f7_q;
  logic [2:0] f3_q;
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_cause_q, tmo_cause_d;

  cls_e       cls;
  logic [3:0] alu_op, alu_ctrl;
  logic [1:0] src_b;
  logic       legal;
  logic       unused_instr;

  // rd/rs1/rs2 are datapath concerns; only the classification fields are latched
  assign unused_instr = ^Instr[24:7];

  control_decode u_dec (
    .opcode_i (op_q),
    .funct3_i (f3_q),
    .funct7_i (f7_q),
    .cls_o    (cls),
    .alu_op_o (alu_op),
    .src_b_o  (src_b),
    .legal_o  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      cnt_q       <= '0;
      tmo_cause_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_cause_q <= tmo_cause_d;
      if (state_q == ST_IDLE && InstrValid) begin
        op_q <= Instr[6:0];
        f3_q <= Instr[14:12];
        f7_q <= Instr[31:25];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_cause_d = tmo_cause_q;
    case (state_q)
      ST_IDLE:   if (InstrValid) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!legal) begin
          state_d     = ST_TRAP;
          tmo_cause_d = 1'b0;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV:          if (MulDivDone) state_d = ST_WB;
`endif
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // ack takes priority over an expiring counter
        if (DmemAck) begin
          state_d = (cls == CLS_LOAD) ? ST_WB : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          state_d     = ST_TRAP;
          tmo_cause_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_TRAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_ctrl        = ALU_ADD;
    ALUSourceB      = SRCB_RS2;
    Dmem1ALUOUT     = 1'b0;
    LoadStoremuxsel = 1'b0;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_ctrl        = alu_op;
      ALUSourceB      = src_b;
      Dmem1ALUOUT     = (cls == CLS_LOAD) || (cls == CLS_STORE);
      LoadStoremuxsel = (cls == CLS_STORE);
    end
  end

  assign ALUControl   = ALUCTRL_W'(alu_ctrl);
  assign ALUSourceA   = 1'b0;
  assign DmemREB      = !(state_q == ST_MEM && cls == CLS_LOAD);
  assign DmemWEB      = !(state_q == ST_MEM && cls == CLS_STORE);
  assign regWrite     = (state_q == ST_WB);
  assign InstrReady   = (state_q == ST_IDLE);
  assign Busy         = (state_q != ST_IDLE);
  assign IllegalInstr = (state_q == ST_TRAP) && !tmo_cause_q;
  assign MemTimeout   = (state_q == ST_TRAP) && tmo_cause_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: each issued instruction pushes its expected
// completion event; a negedge monitor pops and compares when the DUT signals one.
module tb_control_unit_mc;

  localparam int TMO = 4;
  localparam int EV_WB = 1, EV_ST = 2, EV_ILL = 3, EV_TMO = 4;

  logic        clk, rst_n, InstrValid, InstrReady, DmemAck;
  logic [31:0] Instr;
  logic [3:0]  ALUControl;
  logic        ALUSourceA, Dmem1ALUOUT, DmemREB, DmemWEB, LoadStoremuxsel;
  logic        regWrite, Busy, IllegalInstr, MemTimeout;
  logic [1:0]  ALUSourceB;
`ifdef CTRL_MULDIV_EN
  logic        MulDivDone;
`endif

  control_unit_mc #(.ALUCTRL_W(4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .Instr(Instr),
    .InstrReady(InstrReady), .DmemAck(DmemAck),
`ifdef CTRL_MULDIV_EN
    .MulDivDone(MulDivDone),
`endif
    .ALUControl(ALUControl), .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
    .Dmem1ALUOUT(Dmem1ALUOUT), .DmemREB(DmemREB), .DmemWEB(DmemWEB),
    .LoadStoremuxsel(LoadStoremuxsel), .regWrite(regWrite), .Busy(Busy),
    .IllegalInstr(IllegalInstr), .MemTimeout(MemTimeout)
  );

  typedef struct {
    int         ev;
    int         at;
    logic [3:0] alu;
    logic [1:0] sb;
    logic [1:0] ls;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mon_ev;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = 0;
      if (regWrite)                mon_ev = EV_WB;
      else if (IllegalInstr)       mon_ev = EV_ILL;
      else if (MemTimeout)         mon_ev = EV_TMO;
      else if (!DmemWEB && DmemAck) mon_ev = EV_ST;
      if (mon_ev != 0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event", mon_ev, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("event_kind", mon_ev, mon_e.ev);
          chk("event_cycle", cyc, mon_e.at);
          chk("event_aluctrl", ALUControl, mon_e.alu);
          chk("event_srcb", ALUSourceB, mon_e.sb);
          chk("event_lsflags", {Dmem1ALUOUT, LoadStoremuxsel}, mon_e.ls);
        end
      end
    end
  end

  // Issue one instruction and walk it to completion, checking strobes and readiness per cycle.
  task automatic run(input logic [31:0] ins, input int ev, input int lat, input logic [3:0] alu,
                     input logic [1:0] sbv, input logic [1:0] ls, input int ack_k,
                     input int md_k, input bit noisy);
    int   n;
    int   nmem;
    bit   is_ld, is_st, in_mem;
    exp_t e;
    is_ld = (ins[6:0] == 7'b0000011);
    is_st = (ins[6:0] == 7'b0100011);
    nmem  = (ack_k > 0) ? ack_k : TMO;
    n = 0;
    @(posedge clk); #1;
    while (!InstrReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_wait_expired", 0, 1);
    Instr      = ins;
    InstrValid = 1'b1;
    e.ev = ev; e.at = cyc + lat; e.alu = alu; e.sb = sbv; e.ls = ls;
    sb_q.push_back(e);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      in_mem = (is_ld || is_st) && (ev != EV_ILL) && c >= 3 && c < 3 + nmem;
      if (c <= lat && noisy) begin
        InstrValid = 1'b1;
        Instr      = $urandom;
        DmemAck    = in_mem ? (c == 2 + ack_k) : 1'b1;
      end else begin
        InstrValid = 1'b0;
        DmemAck    = in_mem && ack_k > 0 && c == 2 + ack_k;
      end
`ifdef CTRL_MULDIV_EN
      MulDivDone = (md_k > 0 && c == md_k);
`else
      if (md_k < 0) chk("md_k_negative", md_k, 0);
`endif
      chk("read_strobe", DmemREB, !(in_mem && is_ld));
      chk("write_strobe", DmemWEB, !(in_mem && is_st));
      chk("instr_ready", InstrReady, c == lat + 1);
    end
    DmemAck = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; InstrValid = 1'b0; Instr = '0; DmemAck = 1'b0;
`ifdef CTRL_MULDIV_EN
    MulDivDone = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", InstrReady, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_regwrite", regWrite, 0);
    chk("rst_reb", DmemREB, 1);
    chk("rst_web", DmemWEB, 1);
    chk("rst_aluctrl", ALUControl, 4'b0010);
    chk("rst_srca", ALUSourceA, 0);
    chk("rst_srcb", ALUSourceB, 2'b00);
    chk("rst_lsflags", {Dmem1ALUOUT, LoadStoremuxsel}, 2'b00);
    chk("rst_causes", {IllegalInstr, MemTimeout}, 2'b00);
    rst_n = 1'b1;

    //   instr         event   lat alu      srcb   ls     ack md noisy
    run(32'h002081B3, EV_WB,  3, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // ADD
    run(32'h402081B3, EV_WB,  3, 4'b0110, 2'b00, 2'b00, 0, 0, 0); // SUB
    run(32'h0020F1B3, EV_WB,  3, 4'b0000, 2'b00, 2'b00, 0, 0, 0); // AND
    run(32'h0020B1B3, EV_WB,  3, 4'b1010, 2'b00, 2'b00, 0, 0, 1); // SLTU, valid/ack noise while busy
    run(32'h4030D193, EV_WB,  3, 4'b1001, 2'b10, 2'b00, 0, 0, 0); // SRAI
    run(32'h0050C193, EV_WB,  3, 4'b0100, 2'b10, 2'b00, 0, 0, 0); // XORI
    run(32'h00209193, EV_WB,  3, 4'b0101, 2'b10, 2'b00, 0, 0, 0); // SLLI
    run(32'h0040A183, EV_WB,  6, 4'b0010, 2'b11, 2'b10, 3, 0, 0); // LW, ack on 3rd MEM cycle
    run(32'h0040A183, EV_WB,  4, 4'b0010, 2'b11, 2'b10, 1, 0, 1); // LW, ack immediately
    run(32'h0040A183, EV_WB,  7, 4'b0010, 2'b11, 2'b10, TMO, 0, 0); // LW, ack as counter expires
    run(32'h0020A423, EV_ST,  4, 4'b0010, 2'b11, 2'b11, 2, 0, 0); // SW, ack on 2nd MEM cycle
    run(32'h0020A423, EV_TMO, 7, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // SW, never acked
    run(32'h0000007F, EV_ILL, 2, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // opcode 1111111
    run(32'h4020E1B3, EV_ILL, 2, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // SUB funct7 with funct3 110
    run(32'h00409183, EV_ILL, 2, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // LH unsupported
`ifdef CTRL_MULDIV_EN
    run(32'h022081B3, EV_WB,  8, 4'b1011, 2'b00, 2'b00, 0, 7, 0); // MUL waits for MulDivDone
`else
    run(32'h022081B3, EV_ILL, 2, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // MUL without RV32M
`endif
    run(32'h002081B3, EV_WB,  3, 4'b0010, 2'b00, 2'b00, 0, 0, 0); // ADD after traps

    // Reset during a store's MEM phase
    @(posedge clk); #1;
    Instr = 32'h0020A423; InstrValid = 1'b1;
    @(posedge clk); #1;
    InstrValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midmem_web_low", DmemWEB, 0);
    rst_n = 1'b0;
    #1;
    chk("midmem_rst_web", DmemWEB, 1);
    chk("midmem_rst_busy", Busy, 0);
    chk("midmem_rst_regwrite", regWrite, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", InstrReady, 1);
    chk("postrst_web", DmemWEB, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle, parametrised control unit for the RV32I core. It accepts one instruction per valid/ready handshake and latches it. It then sequences DECODE, EXEC, MEM and WB states, driving the ALU, data-memory and register-file control lines. Unlike the single-cycle decoder, it holds memory strobes until the data memory acknowledges, enforces a memory timeout and flags illegal instructions. It sits between instruction fetch and the EX/MEM datapath.

## Interface
- ALUCTRL_W, 4: ALUControl width, ≥4; bits above [3:0] are driven 0.
- MEM_TIMEOUT, 15: maximum cycles in MEM without DmemAck; range 1..255.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- InstrValid  in  1  instruction offered.
- Instr  in  32  instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25].
- InstrReady  out  1  high only in IDLE.
- DmemAck  in  1  data memory completed the access this cycle.
- ALUControl  out  ALUCTRL_W  ALU operation.
- ALUSourceA  out  1  always 0 (rs1).
- ALUSourceB  out  2  00 rs2, 10 I-immediate/shamt, 11 load/store offset.
- Dmem1ALUOUT  out  1  1 for load/store.
- DmemREB  out  1  read strobe, active-low.
- DmemWEB  out  1  write strobe, active-low.
- LoadStoremuxsel  out  1  1 for store.
- regWrite  out  1  register-file write enable.
- Busy  out  1  state ≠ IDLE.
- IllegalInstr  out  1  one-cycle pulse in TRAP for an undecodable instruction.
- MemTimeout  out  1  one-cycle pulse in TRAP after a timeout.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: InstrValid=1 latches Instr; next state DECODE. Otherwise stay in IDLE.
- DECODE: the instruction is classified from the latched word.
  - Illegal → TRAP with the illegal cause.
  - Otherwise → EXEC.
- EXEC: ALU controls valid.
  - Load/store → MEM.
  - Otherwise → WB.
- MEM (load): DmemREB=0. MEM (store): DmemWEB=0. The strobe is held until DmemAck.
  - Ack on a load → WB.
  - Ack on a store → IDLE.
  - Wait counter reaches MEM_TIMEOUT → TRAP with the timeout cause.
- WB: regWrite=1 for exactly one cycle → IDLE. Writes to rd=x0 still assert regWrite; the register file ignores them.
- TRAP: pulse the cause flag for one cycle → IDLE. No regWrite and no strobes.
- Decode (opcode 0110011 R-type, 0010011 I-type; ALUSourceB 00 for R-type, 10 for I-type):
  - ADD/ADDI 0010.
  - SUB 0110 (funct7 0100000, R-type only).
  - AND/ANDI 0000.
  - OR/ORI 0001.
  - XOR/XORI 0100.
  - SLT/SLTI 0111.
  - SLTU/SLTIU 1010.
  - SLL/SLLI 0101.
  - SRL/SRLI 1000.
  - SRA/SRAI 1001.
- Load (0000011, funct3 010) and store (0100011, funct3 010): ALUControl 0010, ALUSourceB 11.
- Illegal: any other opcode or funct3. Also illegal: an R-type funct7 other than 0000000/0100000, or funct7 0100000 outside SUB/SRA/SRAI.
- Outputs are decoded from the registered state and latched instruction; no input-to-output combinational path except none.
- Outside EXEC/MEM/WB, controls sit at idle values: ALUControl 0010, ALUSourceB 00, Dmem1ALUOUT 0, LoadStoremuxsel 0.

## Timing
- Reset values: state IDLE, InstrReady 1, Busy 0, regWrite 0, DmemREB 1, DmemWEB 1, ALUControl 0010, ALUSourceA 0, ALUSourceB 00, Dmem1ALUOUT 0, LoadStoremuxsel 0, IllegalInstr 0, MemTimeout 0, wait counter 0.
- ALU op accepted at edge N: DECODE N+1, EXEC N+2, WB N+3, InstrReady N+4.
- Load acked k cycles after entering MEM (k≥1): WB follows the ack edge.
- Timeout: strobe held for exactly MEM_TIMEOUT cycles, then TRAP.
- DmemAck in the same cycle the counter expires: ack wins.
- DmemAck outside MEM is ignored.
- InstrValid while Busy is ignored; the producer holds it until InstrReady.
- rst_n low mid-MEM: strobes deassert asynchronously; no write completes.

## Configuration
- CTRL_MULDIV_EN defined: RV32M is decoded (0110011, funct7 0000001).
  - ALUControl 1011+funct3[1:0] for MUL variants, 11xx-coded DIV/REM per funct3.
  - Adds input MulDivDone. EXEC stays until MulDivDone=1, then WB.
- CTRL_MULDIV_EN undefined: funct7 0000001 is illegal and the port is absent.

## Structure
- ctrl_pkg: state enum, opcode constants, ALU op codes, ALUSourceB codes.
- Sub-module control_decode: combinational classifier from the latched instruction to class, ALU op, source select and legal flag. The FSM, counter and output registers stay in control_unit_mc.

## Test plan
- Reset mid-MEM on a store: deassert rst_n → DmemWEB=1 immediately; after release, InstrReady=1.
- ADD x3,x1,x2 accepted at cycle 0 → ALUControl 0010, ALUSourceB 00 at cycle 2; regWrite=1 only at cycle 3; InstrReady at cycle 4.
- LW, DmemAck at the 3rd MEM cycle → DmemREB=0 for 3 cycles, then regWrite one cycle, ALUSourceB 11.
- SW, DmemAck never, MEM_TIMEOUT=4 → DmemWEB=0 for 4 cycles, MemTimeout pulse, regWrite stays 0.
- Opcode 1111111, and SUB-encoded funct7 with funct3 110 → IllegalInstr pulse at cycle 2, no regWrite.
- SRAI (funct7 0100000, funct3 101, opcode 0010011) → ALUControl 1001, ALUSourceB 10; with CTRL_MULDIV_EN, MUL waits for MulDivDone after 5 cycles, then WB.
